// File: rtl/cci_test_mmio_rsp_arb_pkg.sv
// Shared types for the MMIO response arbiter: response payload, source IDs, source count.
package cci_test_mmio_rsp_arb_pkg;

    localparam int unsigned MMIO_TID_WIDTH  = 9;
    localparam int unsigned MMIO_DATA_WIDTH = 64;
    localparam int unsigned NUM_MMIO_SRCS   = 2;

    typedef struct packed {
        logic [MMIO_TID_WIDTH-1:0]  tid;
        logic [MMIO_DATA_WIDTH-1:0] data;
    } t_mmio_rsp;

    typedef enum logic {
        SRC_CSR = 1'b0,
        SRC_AFU = 1'b1
    } t_mmio_src;

endpackage

// File: rtl/cci_test_mmio_rsp_fifo.sv
// Per-source response queue with registered wrap-bit pointers; reports a drop
// (ovf) when a write hits a full queue that is not being popped on the same edge.
module cci_test_mmio_rsp_fifo
    import cci_test_mmio_rsp_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  t_mmio_rsp                  wr_data,
    input  logic                       rd_en,
    output t_mmio_rsp                  rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    t_mmio_rsp     mem [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop on the same edge frees the slot, so a write to a full queue still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign ovf   = wr_en && full && !do_rd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cci_test_mmio_rsp_arb.sv
// Round-robin merge of CSR and AFU MMIO read responses onto the c2Tx response channel.
// Optional statistics outputs are built when MMIO_RSP_ARB_STATS_EN is defined.
module cci_test_mmio_rsp_arb
    import cci_test_mmio_rsp_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TID_WIDTH  = MMIO_TID_WIDTH,
    parameter int unsigned DATA_WIDTH = MMIO_DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   csr_rsp_valid,
    input  logic [TID_WIDTH-1:0]                   csr_rsp_tid,
    input  logic [DATA_WIDTH-1:0]                  csr_rsp_data,
    input  logic                                   afu_rsp_valid,
    input  logic [TID_WIDTH-1:0]                   afu_rsp_tid,
    input  logic [DATA_WIDTH-1:0]                  afu_rsp_data,
    output logic                                   mmio_rsp_valid,
    output logic [TID_WIDTH-1:0]                   mmio_rsp_tid,
    output logic [DATA_WIDTH-1:0]                  mmio_rsp_data,
    output logic [NUM_MMIO_SRCS-1:0]               ovf_err
`ifdef MMIO_RSP_ARB_STATS_EN
    ,
    output logic [31:0]                            stat_conflicts,
    output logic [2*($clog2(FIFO_DEPTH)+1)-1:0]    stat_max_occ
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    t_mmio_rsp [NUM_MMIO_SRCS-1:0]             wr_rsp;
    t_mmio_rsp [NUM_MMIO_SRCS-1:0]             head;
    logic      [NUM_MMIO_SRCS-1:0]             wr_en;
    logic      [NUM_MMIO_SRCS-1:0]             pop;
    logic      [NUM_MMIO_SRCS-1:0]             empty;
    logic      [NUM_MMIO_SRCS-1:0]             full;
    logic      [NUM_MMIO_SRCS-1:0]             ovf;
    logic      [NUM_MMIO_SRCS-1:0][CNT_W-1:0]  count;
    t_mmio_src                                 rr_next;
    t_mmio_src                                 grant;
    logic                                      any_pending;

    always_comb begin
        wr_en               = '0;
        wr_rsp              = '0;
        wr_en[SRC_CSR]      = csr_rsp_valid;
        wr_rsp[SRC_CSR].tid  = MMIO_TID_WIDTH'(csr_rsp_tid);
        wr_rsp[SRC_CSR].data = MMIO_DATA_WIDTH'(csr_rsp_data);
        wr_en[SRC_AFU]      = afu_rsp_valid;
        wr_rsp[SRC_AFU].tid  = MMIO_TID_WIDTH'(afu_rsp_tid);
        wr_rsp[SRC_AFU].data = MMIO_DATA_WIDTH'(afu_rsp_data);
    end

    for (genvar s = 0; s < NUM_MMIO_SRCS; s++) begin : g_fifo
        cci_test_mmio_rsp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_en[s]),
            .wr_data (wr_rsp[s]),
            .rd_en   (pop[s]),
            .rd_data (head[s]),
            .empty   (empty[s]),
            .full    (full[s]),
            .count   (count[s]),
            .ovf     (ovf[s])
        );
    end

    // rr_next names the source that wins when both queues hold a response.
    always_comb begin
        pop         = '0;
        grant       = SRC_CSR;
        any_pending = !(&empty);
        if (!empty[SRC_CSR] && !empty[SRC_AFU]) begin
            grant = rr_next;
        end else if (!empty[SRC_AFU]) begin
            grant = SRC_AFU;
        end
        if (any_pending) pop[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mmio_rsp_valid <= 1'b0;
            mmio_rsp_tid   <= '0;
            mmio_rsp_data  <= '0;
            ovf_err        <= '0;
            rr_next        <= SRC_CSR;
        end else begin
            mmio_rsp_valid <= any_pending;
            if (any_pending) begin
                mmio_rsp_tid  <= TID_WIDTH'(head[grant].tid);
                mmio_rsp_data <= DATA_WIDTH'(head[grant].data);
                rr_next       <= (grant == SRC_CSR) ? SRC_AFU : SRC_CSR;
            end
            ovf_err <= ovf_err | ovf;
        end
    end

`ifdef MMIO_RSP_ARB_STATS_EN
    // High-water marks follow the registered queue counts, so they trail by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_conflicts <= '0;
            stat_max_occ   <= '0;
        end else begin
            if (csr_rsp_valid && afu_rsp_valid && (stat_conflicts != '1)) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
            for (int s = 0; s < NUM_MMIO_SRCS; s++) begin
                if (count[s] > stat_max_occ[s*CNT_W +: CNT_W]) begin
                    stat_max_occ[s*CNT_W +: CNT_W] <= count[s];
                end
            end
        end
    end

    logic unused_fifo_full;
    assign unused_fifo_full = ^full;
`else
    logic unused_fifo_status;
    assign unused_fifo_status = ^{full, count};
`endif

endmodule

// File: tb/tb_cci_test_mmio_rsp_arb.sv
// Randomized self-checking bench for cci_test_mmio_rsp_arb against a queue-level reference model.
module tb_cci_test_mmio_rsp_arb;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 9;
    localparam int unsigned DW    = 64;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          csr_rsp_valid;
    logic [TW-1:0] csr_rsp_tid;
    logic [DW-1:0] csr_rsp_data;
    logic          afu_rsp_valid;
    logic [TW-1:0] afu_rsp_tid;
    logic [DW-1:0] afu_rsp_data;
    logic          mmio_rsp_valid;
    logic [TW-1:0] mmio_rsp_tid;
    logic [DW-1:0] mmio_rsp_data;
    logic [1:0]    ovf_err;
`ifdef MMIO_RSP_ARB_STATS_EN
    logic [31:0]     stat_conflicts;
    logic [2*CW-1:0] stat_max_occ;
`endif

    cci_test_mmio_rsp_arb #(
        .FIFO_DEPTH (DEPTH),
        .TID_WIDTH  (TW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_rsp_valid  (csr_rsp_valid),
        .csr_rsp_tid    (csr_rsp_tid),
        .csr_rsp_data   (csr_rsp_data),
        .afu_rsp_valid  (afu_rsp_valid),
        .afu_rsp_tid    (afu_rsp_tid),
        .afu_rsp_data   (afu_rsp_data),
        .mmio_rsp_valid (mmio_rsp_valid),
        .mmio_rsp_tid   (mmio_rsp_tid),
        .mmio_rsp_data  (mmio_rsp_data),
        .ovf_err        (ovf_err)
`ifdef MMIO_RSP_ARB_STATS_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_max_occ   (stat_max_occ)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per source, the last-served source, sticky drop flags.
    logic [TW+DW-1:0] q_csr[$];
    logic [TW+DW-1:0] q_afu[$];
    logic             m_valid;
    logic [TW-1:0]    m_tid;
    logic [DW-1:0]    m_data;
    logic [1:0]       m_ovf;
    int               last_grant;
    int               m_conf;
    int               m_max[2];

    task automatic model_clear();
        q_csr.delete();
        q_afu.delete();
        m_valid    = 1'b0;
        m_tid      = '0;
        m_data     = '0;
        m_ovf      = 2'b00;
        last_grant = 1;
        m_conf     = 0;
        m_max[0]   = 0;
        m_max[1]   = 0;
    endtask

    task automatic step(input logic cv, input logic [TW-1:0] ct, input logic [DW-1:0] cd,
                        input logic av, input logic [TW-1:0] at, input logic [DW-1:0] ad);
        int sc;
        int sa;
        int pick;
        csr_rsp_valid = cv;
        csr_rsp_tid   = ct;
        csr_rsp_data  = cd;
        afu_rsp_valid = av;
        afu_rsp_tid   = at;
        afu_rsp_data  = ad;
        sc = q_csr.size();
        sa = q_afu.size();
        if (sc > m_max[0]) m_max[0] = sc;
        if (sa > m_max[1]) m_max[1] = sa;
        if (cv && av) m_conf++;
        pick = -1;
        if (sc > 0 && sa > 0) pick = 1 - last_grant;
        else if (sc > 0)      pick = 0;
        else if (sa > 0)      pick = 1;
        m_valid = (pick >= 0);
        if (pick == 0) {m_tid, m_data} = q_csr.pop_front();
        if (pick == 1) {m_tid, m_data} = q_afu.pop_front();
        if (pick >= 0) last_grant = pick;
        if (cv) begin
            if (q_csr.size() < DEPTH) q_csr.push_back({ct, cd});
            else m_ovf[0] = 1'b1;
        end
        if (av) begin
            if (q_afu.size() < DEPTH) q_afu.push_back({at, ad});
            else m_ovf[1] = 1'b1;
        end
        @(posedge clk);
        #1;
        csr_rsp_valid = 1'b0;
        afu_rsp_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset(input logic noise);
        reset_n       = 1'b0;
        csr_rsp_valid = noise;
        afu_rsp_valid = noise;
        csr_rsp_tid   = TW'($urandom);
        afu_rsp_tid   = TW'($urandom);
        csr_rsp_data  = rnd64();
        afu_rsp_data  = rnd64();
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        csr_rsp_valid = 1'b0;
        afu_rsp_valid = 1'b0;
        model_clear();
        checks++;
        if (mmio_rsp_valid !== 1'b0 || mmio_rsp_tid !== '0 || mmio_rsp_data !== '0 || ovf_err !== 2'b00) begin
            errors++;
            $display("FAIL reset: got v=%b tid=%h data=%h ovf=%b, want all zero",
                     mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err);
        end
`ifdef MMIO_RSP_ARB_STATS_EN
        checks++;
        if (stat_conflicts !== 32'd0 || stat_max_occ !== '0) begin
            errors++;
            $display("FAIL reset_stats: got conf=%0d occ=%h, want 0/0", stat_conflicts, stat_max_occ);
        end
`endif
    endtask

    task automatic test_single();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 9'h011, 64'h0000_0000_DEAD_BEEF, 1'b0, '0, '0);
            else        step(1'b0, '0, '0, 1'b0, '0, '0);
            checks++;
            if (mmio_rsp_valid !== m_valid || mmio_rsp_tid !== m_tid || mmio_rsp_data !== m_data || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL single cyc %0d: got v=%b tid=%h data=%h ovf=%b, want v=%b tid=%h data=%h ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err, m_valid, m_tid, m_data, m_ovf);
            end
        end
    endtask

    task automatic test_simultaneous();
        test_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 9'h001, rnd64(), 1'b1, 9'h002, rnd64());
            else        step(1'b0, '0, '0, 1'b0, '0, '0);
            checks++;
            if (mmio_rsp_valid !== m_valid || mmio_rsp_tid !== m_tid || mmio_rsp_data !== m_data || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL simultaneous cyc %0d: got v=%b tid=%h data=%h ovf=%b, want v=%b tid=%h data=%h ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err, m_valid, m_tid, m_data, m_ovf);
            end
        end
    endtask

    task automatic test_both_stream();
        test_reset(1'b0);
        for (int i = 0; i < 8 + 2*DEPTH + 3; i++) begin
            if (i < 8) step(1'b1, TW'(9'h100 + i), rnd64(), 1'b1, TW'(9'h080 + i), rnd64());
            else       step(1'b0, '0, '0, 1'b0, '0, '0);
            checks++;
            if (mmio_rsp_valid !== m_valid || mmio_rsp_tid !== m_tid || mmio_rsp_data !== m_data || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL both_stream cyc %0d: got v=%b tid=%h data=%h ovf=%b, want v=%b tid=%h data=%h ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err, m_valid, m_tid, m_data, m_ovf);
            end
        end
`ifdef MMIO_RSP_ARB_STATS_EN
        checks++;
        if (stat_conflicts !== 32'(m_conf) || stat_max_occ !== {CW'(m_max[1]), CW'(m_max[0])}) begin
            errors++;
            $display("FAIL both_stream_stats: got conf=%0d occ=%h, want conf=%0d occ=%h",
                     stat_conflicts, stat_max_occ, m_conf, {CW'(m_max[1]), CW'(m_max[0])});
        end
`endif
    endtask

    task automatic test_csr_stream();
        test_reset(1'b0);
        for (int i = 0; i < 23; i++) begin
            if (i < 20) step(1'b1, TW'($urandom), rnd64(), 1'b0, '0, '0);
            else        step(1'b0, '0, '0, 1'b0, '0, '0);
            checks++;
            if (mmio_rsp_valid !== m_valid || mmio_rsp_tid !== m_tid || mmio_rsp_data !== m_data || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL csr_stream cyc %0d: got v=%b tid=%h data=%h ovf=%b, want v=%b tid=%h data=%h ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err, m_valid, m_tid, m_data, m_ovf);
            end
        end
    endtask

    task automatic test_reset_traffic();
        test_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, TW'($urandom), rnd64(), 1'b1, TW'($urandom), rnd64());
            checks++;
            if (mmio_rsp_valid !== m_valid || mmio_rsp_tid !== m_tid || mmio_rsp_data !== m_data || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL reset_traffic fill %0d: got v=%b tid=%h data=%h ovf=%b, want v=%b tid=%h data=%h ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err, m_valid, m_tid, m_data, m_ovf);
            end
        end
        checks++;
        if (q_csr.size() + q_afu.size() != 3) begin
            errors++;
            $display("FAIL reset_traffic_setup: queued %0d, want 3", q_csr.size() + q_afu.size());
        end
        test_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0);
            checks++;
            if (mmio_rsp_valid !== 1'b0 || mmio_rsp_valid !== m_valid || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL reset_traffic cyc %0d: got v=%b tid=%h ovf=%b, want v=0 ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, ovf_err, m_ovf);
            end
        end
    endtask

    task automatic test_random();
        int pct;
        test_reset(1'b0);
        for (int i = 0; i < 400 + 2*DEPTH + 2; i++) begin
            pct = ((i / 50) % 2 == 1) ? 85 : 35;
            if (i < 400)
                step($urandom_range(0, 99) < pct, TW'($urandom), rnd64(),
                     $urandom_range(0, 99) < pct, TW'($urandom), rnd64());
            else
                step(1'b0, '0, '0, 1'b0, '0, '0);
            checks++;
            if (mmio_rsp_valid !== m_valid || mmio_rsp_tid !== m_tid || mmio_rsp_data !== m_data || ovf_err !== m_ovf) begin
                errors++;
                $display("FAIL random cyc %0d: got v=%b tid=%h data=%h ovf=%b, want v=%b tid=%h data=%h ovf=%b",
                         i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ovf_err, m_valid, m_tid, m_data, m_ovf);
            end
        end
`ifdef MMIO_RSP_ARB_STATS_EN
        checks++;
        if (stat_conflicts !== 32'(m_conf) || stat_max_occ !== {CW'(m_max[1]), CW'(m_max[0])}) begin
            errors++;
            $display("FAIL random_stats: got conf=%0d occ=%h, want conf=%0d occ=%h",
                     stat_conflicts, stat_max_occ, m_conf, {CW'(m_max[1]), CW'(m_max[0])});
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        csr_rsp_valid = 1'b0;
        afu_rsp_valid = 1'b0;
        csr_rsp_tid   = '0;
        afu_rsp_tid   = '0;
        csr_rsp_data  = '0;
        afu_rsp_data  = '0;
        model_clear();
        #1;
        test_reset(1'b0);
        test_single();
        test_simultaneous();
        test_both_stream();
        test_csr_stream();
        test_reset_traffic();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
